u109_pci_arbiter: RTL and testbench
===================================

// Module: u109_pci_arbiter
// PURPOSE
//  Central PCI bus arbiter for the bridge: shares the PCI bus, and with it the bridge FIFO, between NUM_REQ PCI masters and the host bridge.
//  - Host = 68040 side driving FIFO writes.
//  - Fair round-robin grant rotation; one idle turnaround clock between owners; latency timer caps bus hold time.
//  - Grant never changes while the FIFO is still draining a burst.
// PARAMETERS
//  NUM_REQ    4   number of PCI master slots (agent IDs 0..NUM_REQ-1); host bridge is agent ID NUM_REQ
//  LAT_TIMER  16  PCICLKs an owner may keep GNT while another agent requests (1..255)
//  ID_W       3   width of GNT_ID; must satisfy 2**ID_W > NUM_REQ
// PORTS
//  PCICLK     in   1        PCI clock; all logic on rising edge
//  nRESET     in   1        asynchronous active-low reset
//  nREQ       in   NUM_REQ  PCI master requests, active low
//  nHOSTREQ   in   1        host bridge request for a CPU-driven PCI cycle, active low
//  nFRAME     in   1        PCI FRAME#, sampled
//  nIRDY      in   1        PCI IRDY#, sampled
//  FIFO_BUSY  in   1        FIFO burst in progress (FIFO READCYCLE); blocks grant change
//  nGNT       out  NUM_REQ  PCI master grants, active low, at most one low
//  nHOSTGNT   out  1        host bridge grant, active low
//  GNT_ID     out  ID_W     current owner ID; NUM_REQ when host or parked
//  BUSIDLE    out  1        registered: nFRAME & nIRDY both high last clock
//  LAT_EXP    out  1        one-clock pulse when the latency timer expires
// BEHAVIOUR
//  Reset (async, nRESET low):
//   - nGNT all 1, nHOSTGNT 1, GNT_ID = NUM_REQ, BUSIDLE 0, LAT_EXP 0.
//   - State PARK, RR pointer = 0, latency counter = 0.
//  Request vector: req[i] = !nREQ[i] for i<NUM_REQ; req[NUM_REQ] = !nHOSTREQ.
//  Round-robin: search starts at (owner+1) mod (NUM_REQ+1); first set req wins.
//   - After reset the pointer starts at 0.
//  States:
//   PARK:
//    - No requests: host grant asserted (bus parked on bridge); host may start a cycle without arbitration.
//    - Any req: winner chosen; go to TURN if the winner is not host, else GRANT(host).
//   GRANT:
//    - Exactly one grant low; GNT_ID = owner.
//    - Owner drops req AND BUSIDLE AND !FIFO_BUSY: go to TURN with the next winner, or to PARK if none.
//    - Another req pending AND owner's transaction started (nFRAME seen low): latency counter increments each clock.
//    - Counter reaches LAT_TIMER-1: pulse LAT_EXP and deassert the owner's grant.
//       Owner completes its current transaction per PCI rules; arbiter waits for BUSIDLE & !FIFO_BUSY, then TURN.
//    - Counter clears on every owner change.
//   TURN:
//    - All grants high for exactly one PCICLK.
//    - Next clock: assert the grant of the latched winner, state GRANT.
//  Grant latency: request to grant assertion = 2 PCICLKs from idle non-host owner (1 arb + 1 turn); 1 PCICLK for the host from PARK.
//  Boundary cases:
//   - FIFO_BUSY high: no grant change regardless of requests or timer; LAT_EXP still pulses once.
//   - Owner reasserts req after TURN began: ignored until its next RR turn.
//   - Simultaneous requests: strict RR order, no fixed priority; host is not favoured except when parking.
//   - Bus not idle when a winner is chosen: stay with grants high until BUSIDLE.
//   - Reset mid-transaction: immediate return to reset values; no partial grant is held.
// TESTING
//  - Reset -> nGNT=4'hF, nHOSTGNT=1; no req for 2 clk -> nHOSTGNT=0, GNT_ID=4.
//  - nREQ=4'b1110 while parked idle -> nHOSTGNT=1 next clk; one clk all high; nGNT=4'b1110, GNT_ID=0.
//  - nREQ=4'b0101 held, each owner drops after one idle bus -> grant order 1,3,1,3; each handover has one all-high clock.
//  - Owner 2 holds with nFRAME low, nREQ[0]=0 -> LAT_EXP after 16 clk; nGNT[2]=1; grant to 0 only after BUSIDLE.
//  - FIFO_BUSY=1 while the owner drops req and bus idle -> grant held; FIFO_BUSY=0 -> TURN next clk.
//  - nRESET low during GRANT(owner 3) -> nGNT=4'hF asynchronously; after release, PARK then host grant.

Source files
------------

// File: rtl/u109_pci_arbiter.sv
// Round-robin PCI bus arbiter for NUM_REQ masters plus the host bridge (agent NUM_REQ).
// Owners hand over through one all-high turnaround clock; a latency timer bounds bus hold time.
//
//   state | meaning
//   PARK  | no owner; host grant driven while nobody requests
//   GRANT | owner_q holds the bus (grant may be withdrawn after latency expiry)
//   TURN  | all grants high; winner_q latched, waiting for an idle bus
module u109_pci_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int LAT_TIMER = 16,
  parameter int ID_W      = 3
) (
  input  logic               pciclk_i,
  input  logic               nreset_i,
  input  logic [NUM_REQ-1:0] nreq_i,
  input  logic               nhostreq_i,
  input  logic               nframe_i,
  input  logic               nirdy_i,
  input  logic               fifo_busy_i,
  output logic [NUM_REQ-1:0] ngnt_o,
  output logic               nhostgnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               busidle_o,
  output logic               lat_exp_o
);

  localparam int              NAG      = NUM_REQ + 1;
  localparam logic [ID_W-1:0] HOST_ID  = ID_W'(NUM_REQ);
  localparam logic [7:0]      LAT_LAST = 8'(LAT_TIMER - 1);

  localparam logic [1:0] ST_PARK  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    winner_q, winner_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               frame_seen_q, frame_seen_d;
  logic               expired_q, expired_d;
  logic               gnt_off_q, gnt_off_d;
  logic               park_gnt_q, park_gnt_d;
  logic               busidle_q;
  logic               lat_exp_q, lat_exp_d;
  logic [NUM_REQ-1:0] ngnt_q, ngnt_d;
  logic               nhostgnt_q, nhostgnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;

  logic [NUM_REQ:0]   req;
  logic [NUM_REQ:0]   owner_mask;
  logic               req_owner;
  logic               other_req;
  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic               handover;
  logic               count_en;

  assign req = {~nhostreq_i, ~nreq_i};

  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < NAG; i++) begin
      owner_mask[i] = (owner_q == ID_W'(i));
    end
  end

  assign req_owner = |(req & owner_mask);
  assign other_req = |(req & ~owner_mask);

  // First requester at or after ptr_q, wrapping through the host slot.
  always_comb begin
    logic [ID_W-1:0] idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = ptr_q;
    for (int k = 0; k < NAG; k++) begin
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
      idx = (idx == HOST_ID) ? '0 : idx + ID_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    winner_d     = winner_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    frame_seen_d = frame_seen_q;
    expired_d    = expired_q;
    gnt_off_d    = gnt_off_q;
    park_gnt_d   = park_gnt_q;
    lat_exp_d    = 1'b0;
    handover     = 1'b0;
    count_en     = 1'b0;

    case (state_q)
      ST_PARK: begin
        if (pick_found && !fifo_busy_i) begin
          park_gnt_d = 1'b0;
          if (pick_id == HOST_ID) begin
            state_d      = ST_GRANT;
            owner_d      = HOST_ID;
            ptr_d        = '0;
            cnt_d        = '0;
            frame_seen_d = 1'b0;
            expired_d    = 1'b0;
            gnt_off_d    = 1'b0;
          end else begin
            state_d  = ST_TURN;
            winner_d = pick_id;
          end
        end else begin
          park_gnt_d = park_gnt_q | ~pick_found;
        end
      end

      ST_GRANT: begin
        handover = (!req_owner || expired_q) && busidle_q && !fifo_busy_i;
        if (handover) begin
          if (pick_found) begin
            state_d  = ST_TURN;
            winner_d = pick_id;
          end else begin
            state_d    = ST_PARK;
            park_gnt_d = 1'b0;
          end
        end else begin
          frame_seen_d = frame_seen_q | ~nframe_i;
          count_en     = other_req && (frame_seen_q || !nframe_i) && !expired_q;
          if (count_en) begin
            if (cnt_q == LAT_LAST) begin
              lat_exp_d = 1'b1;
              expired_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          // An expired owner loses GNT only once the FIFO burst is finished.
          if (expired_d && !fifo_busy_i) begin
            gnt_off_d = 1'b1;
          end
        end
      end

      ST_TURN: begin
        if (busidle_q && !fifo_busy_i) begin
          state_d      = ST_GRANT;
          owner_d      = winner_q;
          ptr_d        = (winner_q == HOST_ID) ? '0 : winner_q + ID_W'(1);
          cnt_d        = '0;
          frame_seen_d = 1'b0;
          expired_d    = 1'b0;
          gnt_off_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_PARK;
      end
    endcase
  end

  always_comb begin
    ngnt_d     = '1;
    nhostgnt_d = 1'b1;
    gnt_id_d   = HOST_ID;
    if (state_d == ST_GRANT) begin
      gnt_id_d = owner_d;
      if (!gnt_off_d) begin
        nhostgnt_d = (owner_d != HOST_ID);
        for (int i = 0; i < NUM_REQ; i++) begin
          ngnt_d[i] = (owner_d != ID_W'(i));
        end
      end
    end else if (state_d == ST_PARK && park_gnt_d) begin
      nhostgnt_d = 1'b0;
    end
  end

  always_ff @(posedge pciclk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q      <= ST_PARK;
      owner_q      <= HOST_ID;
      winner_q     <= HOST_ID;
      ptr_q        <= '0;
      cnt_q        <= '0;
      frame_seen_q <= 1'b0;
      expired_q    <= 1'b0;
      gnt_off_q    <= 1'b0;
      park_gnt_q   <= 1'b0;
      busidle_q    <= 1'b0;
      lat_exp_q    <= 1'b0;
      ngnt_q       <= '1;
      nhostgnt_q   <= 1'b1;
      gnt_id_q     <= HOST_ID;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      winner_q     <= winner_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      frame_seen_q <= frame_seen_d;
      expired_q    <= expired_d;
      gnt_off_q    <= gnt_off_d;
      park_gnt_q   <= park_gnt_d;
      busidle_q    <= nframe_i & nirdy_i;
      lat_exp_q    <= lat_exp_d;
      ngnt_q       <= ngnt_d;
      nhostgnt_q   <= nhostgnt_d;
      gnt_id_q     <= gnt_id_d;
    end
  end

  assign ngnt_o     = ngnt_q;
  assign nhostgnt_o = nhostgnt_q;
  assign gnt_id_o   = gnt_id_q;
  assign busidle_o  = busidle_q;
  assign lat_exp_o  = lat_exp_q;

endmodule

// File: tb/tb_u109_pci_arbiter.sv
// Bench for u109_pci_arbiter: request episodes push the expected next owner and grant cycle
// into a queue; a negedge monitor pops on every new grant after an all-high clock.
module tb_u109_pci_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LAT_TIMER = 16;
  localparam int ID_W = 3;
  localparam int NAG = NUM_REQ + 1;
  localparam int HOST = NUM_REQ;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_REQ-1:0] nreq;
  logic               nhostreq;
  logic               nframe;
  logic               nirdy;
  logic               fifo_busy;
  logic [NUM_REQ-1:0] ngnt;
  logic               nhostgnt;
  logic [ID_W-1:0]    gnt_id;
  logic               busidle;
  logic               lat_exp;

  always #5 clk = ~clk;

  u109_pci_arbiter #(.NUM_REQ(NUM_REQ), .LAT_TIMER(LAT_TIMER), .ID_W(ID_W)) dut (
    .pciclk_i   (clk),
    .nreset_i   (rst_n),
    .nreq_i     (nreq),
    .nhostreq_i (nhostreq),
    .nframe_i   (nframe),
    .nirdy_i    (nirdy),
    .fifo_busy_i(fifo_busy),
    .ngnt_o     (ngnt),
    .nhostgnt_o (nhostgnt),
    .gnt_id_o   (gnt_id),
    .busidle_o  (busidle),
    .lat_exp_o  (lat_exp)
  );

  typedef struct {
    int agent;
    int at;
  } exp_t;

  exp_t     exp_q[$];
  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  bit       mon_en = 1'b0;
  logic [4:0] prev_gl = '0;
  int       drop_cyc = 0;

  // Reference model: who owns the bus and where the round-robin search starts.
  bit parked = 1'b1;
  int owner = HOST;
  int ptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic int rr_winner(input logic [4:0] r, input int start);
    int rv;
    int idx;
    rv = int'(r);
    for (int k = 0; k < NAG; k++) begin
      idx = (start + k) % NAG;
      if (((rv >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [4:0] gl;
    int ag;
    exp_t e;
    gl = {~nhostgnt, ~ngnt};
    if (rst_n === 1'b1) begin
      checks++;
      if (!$onehot0(gl)) begin
        failures++;
        $display("FAIL grant_onehot got=%b want=at_most_one_low", gl);
      end
      if (gl == 5'd0 && prev_gl != 5'd0) drop_cyc = cyc;
      if (mon_en && gl != 5'd0 && prev_gl == 5'd0) begin
        ag = -1;
        for (int i = 0; i < NAG; i++) if (gl[i] && ag < 0) ag = i;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant got_agent=%0d want=none cycle=%0d", ag, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("grant_owner", ag, e.agent);
          chk("grant_id", int'(gnt_id), e.agent);
          chk("grant_cycle", cyc, e.at);
          chk("turnaround_clocks", cyc - drop_cyc, 1);
        end
      end
      if (mon_en) chk("lat_exp_quiet", int'(lat_exp), 0);
      prev_gl = gl;
    end else begin
      prev_gl = '0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One handover: the owner drops its request, r requests, bus and/or FIFO busy for 'hold' clocks.
  task automatic episode(input logic [4:0] r_in, input int hold, input bit busy_hold);
    logic [4:0] r;
    int w;
    int rel;
    int lat_add;
    int t;
    r = r_in;
    if (!parked) r = r & ~(5'b00001 << owner);
    if (parked && r == 5'd0) r = 5'b00001 << $urandom_range(0, 4);
    w = rr_winner(r, ptr);
    nreq = ~r[3:0];
    nhostreq = ~r[4];
    fifo_busy = (hold > 0);
    nframe = !(hold > 0 && busy_hold);
    nirdy = nframe;
    if (hold > 0) step(hold);
    fifo_busy = 1'b0;
    nframe = 1'b1;
    nirdy = 1'b1;
    rel = cyc;
    if (parked) lat_add = 2;
    else lat_add = (hold > 0 && busy_hold) ? 3 : 2;
    if (parked && w == HOST) begin
      // Host already holds the parked grant: ownership changes with no visible edge.
      parked = 1'b0;
      owner = HOST;
      ptr = 0;
      step(3);
    end else begin
      exp_q.push_back('{(w < 0) ? HOST : w, rel + lat_add});
      if (w < 0) begin
        parked = 1'b1;
      end else begin
        parked = 1'b0;
        owner = w;
        ptr = (w + 1) % NAG;
      end
      t = 0;
      while (exp_q.size() != 0 && t < 20) begin
        @(posedge clk);
        t++;
      end
      #1;
      if (exp_q.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL grant_timeout got=none want_agent=%0d", exp_q[0].agent);
        exp_q.delete();
      end
    end
    step($urandom_range(1, 3));
  endtask

  initial begin
    rst_n = 1'b0;
    nreq = '1;
    nhostreq = 1'b1;
    nframe = 1'b1;
    nirdy = 1'b1;
    fifo_busy = 1'b0;
    step(3);
    chk("rst_ngnt", int'(ngnt), 15);
    chk("rst_nhostgnt", int'(nhostgnt), 1);
    chk("rst_gnt_id", int'(gnt_id), HOST);
    chk("rst_busidle", int'(busidle), 0);
    chk("rst_lat_exp", int'(lat_exp), 0);
    rst_n = 1'b1;
    step(2);
    chk("park_nhostgnt", int'(nhostgnt), 0);
    chk("park_gnt_id", int'(gnt_id), HOST);
    chk("park_ngnt", int'(ngnt), 15);
    chk("park_busidle", int'(busidle), 1);

    mon_en = 1'b1;
    episode(5'b00001, 0, 1'b0);
    episode(5'b01010, 2, 1'b1);
    episode(5'b01000, 1, 1'b0);
    episode(5'b00010, 0, 1'b0);
    episode(5'b01000, 3, 1'b1);

    // Asynchronous reset in the middle of a clock while master 3 owns the bus.
    chk("pre_reset_owner", int'(gnt_id), 3);
    mon_en = 1'b0;
    #3;
    rst_n = 1'b0;
    nreq = '1;
    nhostreq = 1'b1;
    #1;
    chk("async_rst_ngnt", int'(ngnt), 15);
    chk("async_rst_nhostgnt", int'(nhostgnt), 1);
    chk("async_rst_gnt_id", int'(gnt_id), HOST);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("rerst_park_first_clk", int'(nhostgnt), 0);
    step(1);
    chk("rerst_park_nhostgnt", int'(nhostgnt), 0);
    parked = 1'b1;
    owner = HOST;
    ptr = 0;
    mon_en = 1'b1;

    // Latency timer: owner 2 keeps FRAME low while master 0 waits.
    episode(5'b00100, 0, 1'b0);
    mon_en = 1'b0;
    nframe = 1'b0;
    nirdy = 1'b0;
    nreq = 4'b1010;
    for (int i = 1; i <= LAT_TIMER; i++) begin
      step(1);
      chk("lat_exp_timing", int'(lat_exp), (i == LAT_TIMER) ? 1 : 0);
      if (i == LAT_TIMER - 1) chk("lat_owner_held", int'(ngnt), 4'b1011);
    end
    chk("lat_gnt_withdrawn", int'(ngnt), 15);
    chk("lat_gnt_id", int'(gnt_id), 2);
    step(1);
    chk("lat_exp_single_pulse", int'(lat_exp), 0);
    step(2);
    chk("lat_wait_busidle", int'(ngnt), 15);
    nframe = 1'b1;
    nirdy = 1'b1;
    step(2);
    chk("lat_turn_clock", int'(ngnt), 15);
    step(1);
    chk("lat_new_owner_ngnt", int'(ngnt), 4'b1110);
    chk("lat_new_owner_id", int'(gnt_id), 0);
    parked = 1'b0;
    owner = 0;
    ptr = 1;
    step(1);
    mon_en = 1'b1;

    for (int n = 0; n < 40; n++) begin
      episode(5'($urandom_range(0, 31)), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    mon_en = 1'b0;
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
